// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a start bit, shifts out data/parity/stop on device clocks and checks the ack.
// Optional ps2c glitch filter enabled by defining PS2_TX_FILTER_EN.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  input  logic       ps2c_i,
  input  logic       ps2d_i,
  output logic       ps2c_oe_o,
  output logic       ps2d_oe_o
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, START, SEND, WAIT_IDLE} state_t;

  state_t        state;
  logic [8:0]    shift;
  logic [CW-1:0] cnt;
  logic [3:0]    bitcnt;
  logic          c_oe, d_oe, done, err;
  logic          c_meta, c_sync, d_meta, d_sync;
  logic          c_line, c_prev;
  logic          fall;

  // Idle bus is high, so synchronisers reset to 1 to avoid a spurious fall after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_meta <= 1'b1;
      c_sync <= 1'b1;
      d_meta <= 1'b1;
      d_sync <= 1'b1;
    end else begin
      c_meta <= ps2c_i;
      c_sync <= c_meta;
      d_meta <= ps2d_i;
      d_sync <= d_meta;
    end
  end

`ifdef PS2_TX_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic [FW-1:0] filt_cnt;
  logic          c_filt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_filt   <= 1'b1;
      filt_cnt <= '0;
    end else if (c_sync == c_filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
      c_filt   <= c_sync;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign c_line = c_filt;
`else
  assign c_line = c_sync;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) c_prev <= 1'b1;
    else        c_prev <= c_line;
  end

  assign fall = c_prev & ~c_line;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      shift  <= '0;
      cnt    <= '0;
      bitcnt <= '0;
      c_oe   <= 1'b0;
      d_oe   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid_i && tx_ready_o) begin
            shift <= {~^tx_data_i, tx_data_i};
            cnt   <= '0;
            c_oe  <= 1'b1;
            d_oe  <= 1'b0;
            state <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt == INH_LAST) begin
            d_oe  <= 1'b1;
            state <= START;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        START: begin
          c_oe   <= 1'b0;
          cnt    <= '0;
          bitcnt <= '0;
          state  <= SEND;
        end
        SEND: begin
          // Expiry takes priority over a coincident device clock edge.
          if (cnt == TO_LAST) begin
            c_oe  <= 1'b0;
            d_oe  <= 1'b0;
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (fall) begin
              bitcnt <= bitcnt + 1'b1;
              if (bitcnt < 4'd9) begin
                d_oe  <= ~shift[0];
                shift <= {1'b0, shift[8:1]};
              end else if (bitcnt == 4'd9) begin
                d_oe <= 1'b0;
              end else if (!d_sync) begin
                state <= WAIT_IDLE;
              end else begin
                err   <= 1'b1;
                state <= IDLE;
              end
            end
          end
        end
        WAIT_IDLE: begin
          if (cnt == TO_LAST) begin
            c_oe  <= 1'b0;
            d_oe  <= 1'b0;
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (c_line && d_sync) begin
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Ready is held off during the done/err pulse so it rises the following cycle.
  assign tx_ready_o = (state == IDLE) && !done && !err;
  assign busy_o     = (state != IDLE);
  assign done_o     = done;
  assign err_o      = err;
  assign ps2c_oe_o  = c_oe;
  assign ps2d_oe_o  = d_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host and captures them.
module tb_ps2_host_tx;
  localparam int INH = 37;
  localparam int TO  = 1500;
  localparam int H   = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, err, ps2c_oe, ps2d_oe;
  logic       dev_c = 1'b0, dev_d = 1'b0;
  logic       ps2c_line, ps2d_line;

  assign ps2c_line = !(ps2c_oe || dev_c);
  assign ps2d_line = !(ps2d_oe || dev_d);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready), .busy_o(busy), .done_o(done), .err_o(err),
    .ps2c_i(ps2c_line), .ps2d_i(ps2d_line), .ps2c_oe_o(ps2c_oe), .ps2d_oe_o(ps2d_oe)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int done_cnt = 0, err_cnt = 0, inh_run = 0, inh_last = 0;

  // Pulse counters and inhibit-length measurement.
  always @(negedge clk) begin
    if (rst_n) begin
      done_cnt = done_cnt + int'(done);
      err_cnt  = err_cnt + int'(err);
      if (ps2c_oe && !ps2d_oe && busy) inh_run = inh_run + 1;
      else begin
        if (inh_run != 0) inh_last = inh_run;
        inh_run = 0;
      end
    end
  end

  typedef struct {
    logic [7:0]  data;
    bit          ack;
    logic [10:0] exp_frame;
    int          exp_done;
    int          exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    int i = 0;
    @(negedge clk);
    while (!tx_ready && i < 200) begin @(negedge clk); i++; end
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (ps2c_line && !ps2d_line && busy) seen = 1'b1;
    end
  endtask

  // Device: samples ps2d after each rising edge, optionally acks on clock 11.
  task automatic dev_frame(input bit ack, output logic [10:0] bits);
    bit seen;
    bits = '0;
    wait_start(seen);
    if (!seen) begin
      check("dev_start_seen", 32'd0, 32'd1);
      return;
    end
    bits[0] = ps2d_line;
    repeat (H) @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      dev_c = 1'b1;
      repeat (H) @(negedge clk);
      dev_c = 1'b0;
      bits[i] = ps2d_line;
      repeat (H) @(negedge clk);
    end
    if (ack) dev_d = 1'b1;
    repeat (H) @(negedge clk);
    dev_c = 1'b1;
    repeat (H) @(negedge clk);
    dev_c = 1'b0;
    repeat (H) @(negedge clk);
    dev_d = 1'b0;
  endtask

  task automatic wait_not_busy();
    int i = 0;
    while (busy && i < 3000) begin @(negedge clk); i++; end
    if (busy) check("busy_drop_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int d0, e0;
    logic [10:0] frame;
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(v.data);
    dev_frame(v.ack, frame);
    wait_not_busy();
    repeat (3) @(negedge clk);
    check("frame", 32'(frame), 32'(v.exp_frame));
    check("done_count", 32'(done_cnt - d0), 32'(v.exp_done));
    check("err_count", 32'(err_cnt - e0), 32'(v.exp_err));
    check("inhibit_len", 32'(inh_last), 32'(INH));
    check("ps2c_oe_idle", 32'(ps2c_oe), 32'd0);
    check("ps2d_oe_idle", 32'(ps2d_oe), 32'd0);
    check("ready_idle", 32'(tx_ready), 32'd1);
    $display("vec %0d data=%02h ack=%0d frame=%03h done=%0d err=%0d", idx, v.data, v.ack,
             frame, done_cnt - d0, err_cnt - e0);
  endtask

  vec_t        vecs[6];
  logic [10:0] frame_a;
  bit          seen_a;
  int          n_a, d_a;

  initial begin
    vecs[0] = '{8'hED, 1'b1, 11'b1_1_11101101_0, 1, 0};
    vecs[1] = '{8'hF4, 1'b1, 11'b1_0_11110100_0, 1, 0};
    vecs[2] = '{8'h00, 1'b1, 11'b1_1_00000000_0, 1, 0};
    vecs[3] = '{8'hFF, 1'b1, 11'b1_1_11111111_0, 1, 0};
    vecs[4] = '{8'h01, 1'b1, 11'b1_0_00000001_0, 1, 0};
    vecs[5] = '{8'hED, 1'b0, 11'b1_1_11101101_0, 0, 1};

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ps2c_oe", 32'(ps2c_oe), 32'd0);
    check("rst_ps2d_oe", 32'(ps2d_oe), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Ready must stay low during the done pulse and rise on the next cycle.
    d_a = done_cnt;
    send_byte(8'hF4);
    fork
      dev_frame(1'b1, frame_a);
      begin
        seen_a = 1'b0;
        for (int i = 0; i < 3000 && !seen_a; i++) begin
          @(negedge clk);
          if (done) seen_a = 1'b1;
        end
        check("f4_done_seen", 32'(seen_a), 32'd1);
        check("f4_ready_during_done", 32'(tx_ready), 32'd0);
        check("f4_err_during_done", 32'(err), 32'd0);
        @(negedge clk);
        check("f4_ready_after_done", 32'(tx_ready), 32'd1);
        check("f4_done_one_cycle", 32'(done), 32'd0);
      end
    join
    check("f4_frame", 32'(frame_a), 32'(11'b1_0_11110100_0));
    $display("seq ready-after-done data=f4 frame=%03h", frame_a);
    wait_not_busy();

    // Device never clocks: timeout after the counter runs out.
    send_byte(8'hA5);
    seen_a = 1'b0;
    for (int i = 0; i < 200 && !seen_a; i++) begin
      @(negedge clk);
      if (ps2c_oe && ps2d_oe) seen_a = 1'b1;
    end
    check("to_start_seen", 32'(seen_a), 32'd1);
    n_a = 0;
    while (!err && n_a < TO + 50) begin @(negedge clk); n_a++; end
    check("to_latency", 32'(n_a), 32'(TO + 1));
    check("to_done", 32'(done), 32'd0);
    check("to_ps2c_oe", 32'(ps2c_oe), 32'd0);
    check("to_ps2d_oe", 32'(ps2d_oe), 32'd0);
    check("to_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("to_err_one_cycle", 32'(err), 32'd0);
    $display("seq timeout data=a5 cycles=%0d", n_a);

    // Valid held with 0x55 during a frame must not start a second one.
    d_a = done_cnt;
    send_byte(8'hED);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    fork
      dev_frame(1'b1, frame_a);
      begin
        seen_a = 1'b0;
        for (int i = 0; i < 3000 && !seen_a; i++) begin
          @(negedge clk);
          if (done) seen_a = 1'b1;
        end
        tx_valid = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    check("hold_frame", 32'(frame_a), 32'(11'b1_1_11101101_0));
    check("hold_done_count", 32'(done_cnt - d_a), 32'd1);
    check("hold_no_second", 32'(busy), 32'd0);
    $display("seq hold-valid frame=%03h done=%0d", frame_a, done_cnt - d_a);

    // Asynchronous reset after the fifth device clock falls.
    send_byte(8'hED);
    wait_start(seen_a);
    check("rst_mid_start_seen", 32'(seen_a), 32'd1);
    repeat (H) @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      dev_c = 1'b1;
      repeat (H) @(negedge clk);
      dev_c = 1'b0;
      repeat (H) @(negedge clk);
    end
    dev_c = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_mid_bit4_driven", 32'(ps2d_oe), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_ps2c_oe", 32'(ps2c_oe), 32'd0);
    check("rst_mid_ps2d_oe", 32'(ps2d_oe), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    dev_c = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    $display("seq reset-mid-frame released");
    run_vec(6, vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
